// File: rtl/button_conditioner.sv
// Multi-channel button/switch conditioner: N-flop synchronizer, tick-sampled
// symmetric debouncer and registered single-cycle rise/fall pulses.
module button_conditioner #(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SAMPLE_CNT_MAX = 62500,
    parameter int unsigned PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned SAMP_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int unsigned DB_W   = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(PULSE_CNT_MAX - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SAMP_W-1:0]                 samp_cnt;
    logic                              tick_c;
    logic [WIDTH-1:0][DB_W-1:0]        cnt_q;
    logic [WIDTH-1:0][DB_W-1:0]        cnt_d;
    logic [WIDTH-1:0]                  deb_d;
    logic [WIDTH-1:0]                  rise_d;
    logic [WIDTH-1:0]                  fall_d;

    // Plain shift chain; stage 0 takes the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shared sample-tick generator.
    assign tick_c = (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= '0;
        end else if (tick_c) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
        end
    end

    // Per-channel debounce next-state; a flip also raises the matching edge pulse.
    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = debounced;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (tick_c) begin
                if (sync_out[i] == debounced[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_d[i]  = '0;
                    deb_d[i]  = ~debounced[i];
                    rise_d[i] = ~debounced[i];
                    fall_d[i] = debounced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            debounced  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            cnt_q      <= cnt_d;
            debounced  <= deb_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: main instance (2ch, 3 stages, tick/4,
// 3 ticks) plus a degenerate instance (tick every cycle, single-tick flip).
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] async_in;
    logic [1:0] sync_out, debounced, rise_pulse, fall_pulse;
    logic [0:0] a2, s2, d2, r2, f2;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = -1;

    button_conditioner #(
        .WIDTH(2), .SYNC_STAGES(3), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .sync_out(sync_out),
        .debounced(debounced), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    button_conditioner #(
        .WIDTH(1), .SYNC_STAGES(3), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1)
    ) dut_min (
        .clk(clk), .rst_n(rst_n), .async_in(a2), .sync_out(s2),
        .debounced(d2), .rise_pulse(r2), .fall_pulse(f2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after edge e (edge 0 is the first edge after reset release).
    task automatic go(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        async_in = 2'b00;
        a2       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        edge_n = -1;
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        async_in = 2'b00;
        a2       = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("por_sync", sync_out, 2'b00);
        check("por_deb", debounced, 2'b00);
        check("por_rise", rise_pulse, 2'b00);
        check("por_fall", fall_pulse, 2'b00);

        // Synchronizer depth: input high for one sampling edge only
        do_reset();
        async_in = 2'b01;
        go(0); async_in = 2'b00;
        go(1);  check("syn_e1", sync_out, 2'b00);
        go(2);  check("syn_e2", sync_out, 2'b01);
        go(3);  check("syn_e3", sync_out, 2'b00);
        go(12); check("syn_deb", debounced, 2'b00);

        // Clean press on both channels, then release
        do_reset();
        async_in = 2'b11;
        go(10); check("press_e10_deb", debounced, 2'b00);
                check("press_e10_rise", rise_pulse, 2'b00);
        go(11); check("press_e11_deb", debounced, 2'b11);
                check("press_e11_rise", rise_pulse, 2'b11);
                check("press_e11_fall", fall_pulse, 2'b00);
        go(12); check("press_e12_rise", rise_pulse, 2'b00);
                check("press_e12_deb", debounced, 2'b11);
        async_in = 2'b00;
        go(26); check("rel_e26_deb", debounced, 2'b11);
                check("rel_e26_fall", fall_pulse, 2'b00);
        go(27); check("rel_e27_deb", debounced, 2'b00);
                check("rel_e27_fall", fall_pulse, 2'b11);
                check("rel_e27_rise", rise_pulse, 2'b00);
        go(28); check("rel_e28_fall", fall_pulse, 2'b00);

        // Bounce on ch0 (low on tick 3 only), ch1 held high
        do_reset();
        async_in = 2'b11;
        go(7);  async_in = 2'b10;
        go(8);  async_in = 2'b11;
        go(10); check("bnc_e10_sync", sync_out, 2'b10);
        go(11); check("bnc_e11_deb", debounced, 2'b10);
                check("bnc_e11_rise", rise_pulse, 2'b10);
        go(15); check("bnc_e15_deb", debounced, 2'b10);
                check("bnc_e15_rise", rise_pulse, 2'b00);
        go(19); check("bnc_e19_deb", debounced, 2'b10);
        go(22); check("bnc_e22_rise", rise_pulse, 2'b00);
        go(23); check("bnc_e23_deb", debounced, 2'b11);
                check("bnc_e23_rise", rise_pulse, 2'b01);

        // Two-cycle low glitch on ch0 that no tick observes
        go(25); async_in = 2'b10;
        go(27); async_in = 2'b11;
        go(29); check("gl_e29_sync", sync_out, 2'b10);
        go(31); check("gl_e31_sync", sync_out, 2'b11);
        go(40); check("gl_e40_deb", debounced, 2'b11);
                check("gl_e40_fall", fall_pulse, 2'b00);

        // Reset mid-operation: ch1 debounced, ch0 count at 2
        do_reset();
        async_in = 2'b10;
        go(11); check("rst_e11_deb", debounced, 2'b10);
        async_in = 2'b11;
        go(20); check("rst_e20_deb", debounced, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_sync", sync_out, 2'b00);
        check("rst_async_deb", debounced, 2'b00);
        check("rst_async_rise", rise_pulse, 2'b00);
        check("rst_async_fall", fall_pulse, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        edge_n = -1;
        rst_n  = 1'b1;
        go(10); check("rst_e10_deb", debounced, 2'b00);
        go(11); check("rst_e11b_deb", debounced, 2'b11);
                check("rst_e11b_rise", rise_pulse, 2'b11);

        // Degenerate instance: debounced trails sync_out by one cycle
        do_reset();
        a2 = 1'b1;
        go(2); check("min_e2_sync", 2'(s2), 2'b01);
               check("min_e2_deb", 2'(d2), 2'b00);
        go(3); check("min_e3_deb", 2'(d2), 2'b01);
               check("min_e3_rise", 2'(r2), 2'b01);
        a2 = 1'b0;
        go(4); check("min_e4_rise", 2'(r2), 2'b00);
               check("min_e4_deb", 2'(d2), 2'b01);
        go(6); check("min_e6_deb", 2'(d2), 2'b01);
        go(7); check("min_e7_deb", 2'(d2), 2'b00);
               check("min_e7_fall", 2'(f2), 2'b01);
        go(8); check("min_e8_fall", 2'(f2), 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
